// File: rtl/qpu_exu_wbck.sv
// Write-back stage: queues ALU-class results, arbitrates against LSU load returns and
// issues one registered register-file write per cycle. LSU return -> write N+1, ALU -> N+2.
// Backpressure: both inputs stall while the ALU FIFO is full; the LSU otherwise always wins.

// Generic synchronous FIFO with occupancy count; no empty-to-head bypass.
// Push accepted when not full; head valid when nonempty.
module qpu_exu_wbck_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign push_rdy = ~full;
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_vld & pop_rdy;

  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

module qpu_exu_wbck #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int DEPTH       = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                   lsu_wbck_i_valid,
  output logic                   lsu_wbck_i_ready,
  input  logic [XLEN-1:0]        lsu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx,
  output logic                   rf_wbck_o_ena,
  output logic [XLEN-1:0]        rf_wbck_o_wdat,
  output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,
  output logic [CW-1:0]          alu_fifo_cnt,
  output logic                   wbck_idle
);

  typedef struct packed {
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic [XLEN-1:0]        wdat;
  } wbck_t;

  wbck_t alu_res;
  wbck_t lsu_res;
  wbck_t head_res;
  wbck_t sel_res;
  logic  fifo_nonempty;
  logic  fifo_full;
  logic  sel_alu;
  logic  sel_lsu;

  assign alu_res.rdidx = alu_wbck_i_rdidx;
  assign alu_res.wdat  = alu_wbck_i_wdat;
  assign lsu_res.rdidx = lsu_wbck_i_rdidx;
  assign lsu_res.wdat  = lsu_wbck_i_wdat;

  qpu_exu_wbck_fifo #(
    .WIDTH ($bits(wbck_t)),
    .DEPTH (DEPTH)
  ) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (alu_wbck_i_valid),
    .push_rdy (alu_wbck_i_ready),
    .push_dat (alu_res),
    .pop_vld  (fifo_nonempty),
    .pop_rdy  (sel_alu),
    .pop_dat  (head_res),
    .full     (fifo_full),
    .cnt      (alu_fifo_cnt)
  );

  // A full FIFO takes priority over the LSU so ALU results cannot starve.
  assign sel_alu          = fifo_nonempty & (~lsu_wbck_i_valid | fifo_full);
  assign sel_lsu          = lsu_wbck_i_valid & ~sel_alu;
  assign lsu_wbck_i_ready = ~fifo_full;

  always_comb begin
    sel_res = lsu_res;
    if (sel_alu) sel_res = head_res;
  end

  // rdidx 0 results are consumed but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wbck_o_ena   <= 1'b0;
      rf_wbck_o_wdat  <= '0;
      rf_wbck_o_rdidx <= '0;
    end else begin
      rf_wbck_o_ena <= (sel_alu | sel_lsu) & (sel_res.rdidx != '0);
      if (sel_alu | sel_lsu) begin
        rf_wbck_o_wdat  <= sel_res.wdat;
        rf_wbck_o_rdidx <= sel_res.rdidx;
      end
    end
  end

  assign wbck_idle = ~fifo_nonempty & ~rf_wbck_o_ena;

endmodule

// File: doc/qpu_exu_wbck.md
Name: qpu_exu_wbck

Overview:
- Write-back stage directly downstream of the ALU datapath. It consumes ALU/LSU/QIU adder results (ALU-class) and LSU load data (long-pipe class).
- ALU-class results go into a small FIFO. A priority arbiter chooses between the FIFO head and the LSU load return.
- It issues at most one registered integer register-file write per cycle.
- It also reports idle status to the commit/flush logic.

Parameters:
XLEN, 32, data width of results and register-file write data.
RFIDX_WIDTH, 5, destination register index width.
DEPTH, 2, ALU-class FIFO entries (power of two, >=2).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
alu_wbck_i_valid  input  1  ALU-class result valid.
alu_wbck_i_ready  output  1  FIFO can accept an ALU-class result.
alu_wbck_i_wdat  input  XLEN  ALU-class result (adder/logic output).
alu_wbck_i_rdidx  input  RFIDX_WIDTH  destination register index.
lsu_wbck_i_valid  input  1  LSU load return valid.
lsu_wbck_i_ready  output  1  LSU return accepted this cycle.
lsu_wbck_i_wdat  input  XLEN  load data.
lsu_wbck_i_rdidx  input  RFIDX_WIDTH  load destination register index.
rf_wbck_o_ena  output  1  register-file write enable (registered).
rf_wbck_o_wdat  output  XLEN  register-file write data (registered).
rf_wbck_o_rdidx  output  RFIDX_WIDTH  register-file write index (registered).
alu_fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.
wbck_idle  output  1  FIFO empty and rf_wbck_o_ena low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rf_wbck_o_ena=0, rf_wbck_o_wdat=0, rf_wbck_o_rdidx=0.
  - FIFO read/write pointers and count = 0; alu_fifo_cnt=0.
  - wbck_idle=1 in the cycle after reset.
- Reset mid-operation:
  - Discards all FIFO contents and any pending output write. No write occurs in the cycle following the reset edge.
  - rst has priority over every other event.
- FIFO:
  - alu_wbck_i_ready = ~full. It does not depend on a same-cycle pop.
  - Enqueue on alu_wbck_i_valid & alu_wbck_i_ready.
  - Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - An empty FIFO with an enqueue does not bypass; the head becomes visible the next cycle.
- Arbitration (combinational, each cycle):
  - sel_alu = fifo_nonempty & (~lsu_wbck_i_valid | full). A full FIFO overrides LSU priority so the ALU path cannot starve.
  - sel_lsu = lsu_wbck_i_valid & ~sel_alu.
  - lsu_wbck_i_ready = ~(fifo_nonempty & full), i.e. ~full.
  - Dequeue when sel_alu.
- Output register:
  - On each edge, rf_wbck_o_ena <= (sel_alu | sel_lsu) & (selected rdidx != 0).
  - wdat and rdidx load the selected source whenever sel_alu | sel_lsu; otherwise they hold.
  - A result with rdidx=0 is consumed (dequeued/handshaken) but never written.
- Latency:
  - LSU handshake in cycle N -> rf_wbck_o_ena in N+1.
  - ALU enqueue in cycle N -> earliest write in N+2. Each cycle an LSU return wins delays it by one cycle.
- Ordering: ALU-class results retire in FIFO order. No ordering is enforced between the ALU and LSU classes; upstream hazard logic owns that.
- Status:
  - alu_fifo_cnt is the registered count.
  - wbck_idle = ~fifo_nonempty & ~rf_wbck_o_ena.
- Throughput: one write per cycle maximum. Back-to-back ALU results sustain one per cycle when no LSU traffic.
- No X-propagation: outputs are always driven from registers or gated logic.

Test Plan:
- Reset, then single ALU result wdat=0x0000_1234, rdidx=5 at cycle 1 -> rf_wbck_o_ena=1, wdat=0x1234, rdidx=5 at cycle 3; wbck_idle=1 at cycle 4.
- FIFO holds 1 entry (rd=3, 0xAAAA) and LSU valid (rd=7, 0x5555) in the same cycle -> LSU written first (rd=7), ALU entry written the next cycle (rd=3); alu_fifo_cnt goes 1->0.
- Saturation, DEPTH=2:
  - Fill with rd=1 and rd=2 while LSU is held valid continuously.
  - alu_wbck_i_ready=0 and lsu_wbck_i_ready=0 while full.
  - rd=1 is written, then rd=2 or the LSU return follows per the arbitration rule.
  - LSU data is never lost; the LSU valid is held stable until ready.
- ALU result with rdidx=0, wdat=0xFFFF_FFFF -> dequeued, rf_wbck_o_ena stays 0, alu_fifo_cnt returns to 0.
- 10 back-to-back ALU results, rd=1..10, wdat=rd*0x11, no LSU traffic -> 10 consecutive writes in order, covering pointer wrap; no bubbles after the first.
- Assert rst with 2 entries queued and ena=1 -> next cycle ena=0, alu_fifo_cnt=0, alu_wbck_i_ready=1; no stale entry is ever written afterwards.
